// File: rtl/axis_frame_serializer.sv
// Whole-frame to pixel-serial AXI-Stream converter: accepts one N_PIX-pixel frame per
// slave beat and replays it one pixel per master beat in raster order with SOF/EOL/EOF flags.
module axis_frame_serializer #(
   parameter int R_I = 5,
   parameter int C_I = 5,
   parameter int W_I = 8,
   localparam int N_PIX = R_I * C_I,
   localparam int CW = $clog2(N_PIX)
) (
   input  logic                   clk,
   input  logic                   rstn,
   output logic                   s_axis_frame_ready,
   input  logic                   s_axis_frame_valid,
   input  logic [N_PIX*W_I-1:0]   s_axis_frame_data,
   input  logic                   m_axis_pixel_ready,
   output logic                   m_axis_pixel_valid,
   output logic [W_I-1:0]         m_axis_pixel_data,
   output logic                   m_axis_pixel_user,
   output logic                   m_axis_pixel_eol,
   output logic                   m_axis_pixel_last
);

   localparam int CCW = (C_I > 1) ? $clog2(C_I) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                 state, state_nxt;
   logic [N_PIX*W_I-1:0]   shreg;
   logic [CW-1:0]          pix_cnt;
   logic [CCW-1:0]         col_cnt;
   logic                   s_load;
   logic                   m_beat;
   logic                   at_last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Ready is combinational on the last beat so a waiting frame loads with no bubble.
   always_comb begin
      state_nxt          = state;
      m_axis_pixel_valid = (state == SEND);
      at_last            = (pix_cnt == CW'(N_PIX - 1));
      m_beat             = m_axis_pixel_valid & m_axis_pixel_ready;
      s_axis_frame_ready = (state == IDLE) | (m_beat & at_last);
      s_load             = s_axis_frame_valid & s_axis_frame_ready;
      if (s_load)
         state_nxt = SEND;
      else if (m_beat && at_last)
         state_nxt = IDLE;
      m_axis_pixel_data  = m_axis_pixel_valid ? shreg[W_I-1:0] : '0;
      m_axis_pixel_user  = m_axis_pixel_valid & (pix_cnt == '0);
      m_axis_pixel_eol   = m_axis_pixel_valid & (col_cnt == CCW'(C_I - 1));
      m_axis_pixel_last  = m_axis_pixel_valid & at_last;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shreg   <= '0;
         pix_cnt <= '0;
         col_cnt <= '0;
      end else if (s_load) begin
         shreg   <= s_axis_frame_data;
         pix_cnt <= '0;
         col_cnt <= '0;
      end else if (m_beat && !at_last) begin
         shreg   <= shreg >> W_I;
         pix_cnt <= pix_cnt + CW'(1);
         if (col_cnt == CCW'(C_I - 1))
            col_cnt <= '0;
         else
            col_cnt <= col_cnt + CCW'(1);
      end
   end

endmodule

// File: tb/tb_axis_frame_serializer.sv
// Scoreboard bench for axis_frame_serializer: a 5x5x8 instance and a 2x3x4 instance,
// each with a queue-based reference model and an independent output monitor.
module tb_axis_frame_serializer;

   typedef struct packed {
      logic [7:0] data;
      logic       user;
      logic       eol;
      logic       last;
   } beat_t;

   typedef logic [7:0] pix_a_t [25];
   typedef logic [7:0] pix_b_t [6];

   logic          clk;
   logic          rstn;
   logic          s_ready_a, s_valid_a, m_ready_a, m_valid_a, user_a, eol_a, last_a;
   logic [199:0]  s_data_a;
   logic [7:0]    m_data_a;
   logic          s_ready_b, s_valid_b, m_ready_b, m_valid_b, user_b, eol_b, last_b;
   logic [23:0]   s_data_b;
   logic [3:0]    m_data_b;

   beat_t sb_a[$];
   beat_t sb_b[$];
   int    checks = 0;
   int    errors = 0;
   int    beats_a = 0;
   int    beats_b = 0;
   int    cyc = 0;
   int    gaps_a = 0;
   int    prev_cyc_a = 0;
   bit    have_prev_a = 0;
   bit    rnd_a = 0;
   bit    rnd_b = 0;
   bit    hold_a = 0;
   bit    hold_b = 0;
   logic [10:0] held_a;
   logic [6:0]  held_b;

   axis_frame_serializer #(.R_I(5), .C_I(5), .W_I(8)) dut_a (
      .clk(clk), .rstn(rstn),
      .s_axis_frame_ready(s_ready_a), .s_axis_frame_valid(s_valid_a), .s_axis_frame_data(s_data_a),
      .m_axis_pixel_ready(m_ready_a), .m_axis_pixel_valid(m_valid_a), .m_axis_pixel_data(m_data_a),
      .m_axis_pixel_user(user_a), .m_axis_pixel_eol(eol_a), .m_axis_pixel_last(last_a)
   );

   axis_frame_serializer #(.R_I(2), .C_I(3), .W_I(4)) dut_b (
      .clk(clk), .rstn(rstn),
      .s_axis_frame_ready(s_ready_b), .s_axis_frame_valid(s_valid_b), .s_axis_frame_data(s_data_b),
      .m_axis_pixel_ready(m_ready_b), .m_axis_pixel_valid(m_valid_b), .m_axis_pixel_data(m_data_b),
      .m_axis_pixel_user(user_b), .m_axis_pixel_eol(eol_b), .m_axis_pixel_last(last_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (rnd_a) m_ready_a = 1'($urandom_range(0, 1));
      if (rnd_b) m_ready_b = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor A: compares the head of the queue whenever a beat is presented.
   always @(negedge clk) begin
      beat_t e;
      if (!rstn) hold_a = 0;
      else begin
         if (hold_a) begin
            chk("hold_valid_a", 32'(m_valid_a), 32'd1);
            chk("hold_outputs_a", 32'({m_data_a, user_a, eol_a, last_a}), 32'(held_a));
         end
         if (m_valid_a) begin
            if (sb_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat_a: got data %0h expected no beat", m_data_a);
            end else begin
               e = sb_a[0];
               chk("data_a", 32'(m_data_a), 32'(e.data));
               chk("user_a", 32'(user_a), 32'(e.user));
               chk("eol_a", 32'(eol_a), 32'(e.eol));
               chk("last_a", 32'(last_a), 32'(e.last));
               chk("s_ready_busy_a", 32'(s_ready_a), 32'(m_ready_a & e.last));
               if (m_ready_a) begin
                  void'(sb_a.pop_front());
                  beats_a++;
                  if (have_prev_a && cyc != prev_cyc_a + 1) gaps_a++;
                  have_prev_a = 1;
                  prev_cyc_a = cyc;
               end
            end
         end else
            chk("s_ready_idle_a", 32'(s_ready_a), 32'd1);
         hold_a = m_valid_a & !m_ready_a;
         held_a = {m_data_a, user_a, eol_a, last_a};
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (!rstn) hold_b = 0;
      else begin
         if (hold_b) begin
            chk("hold_valid_b", 32'(m_valid_b), 32'd1);
            chk("hold_outputs_b", 32'({m_data_b, user_b, eol_b, last_b}), 32'(held_b));
         end
         if (m_valid_b) begin
            if (sb_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat_b: got data %0h expected no beat", m_data_b);
            end else begin
               e = sb_b[0];
               chk("data_b", 32'(m_data_b), 32'(e.data));
               chk("user_b", 32'(user_b), 32'(e.user));
               chk("eol_b", 32'(eol_b), 32'(e.eol));
               chk("last_b", 32'(last_b), 32'(e.last));
               chk("s_ready_busy_b", 32'(s_ready_b), 32'(m_ready_b & e.last));
               if (m_ready_b) begin
                  void'(sb_b.pop_front());
                  beats_b++;
               end
            end
         end else
            chk("s_ready_idle_b", 32'(s_ready_b), 32'd1);
         hold_b = m_valid_b & !m_ready_b;
         held_b = {m_data_b, user_b, eol_b, last_b};
      end
   end

   // Reference model: raster order, flags from row/column position of each pixel.
   task automatic send_a(input pix_a_t pix, input bit keep);
      logic [199:0] d;
      beat_t b;
      bit got;
      for (int i = 0; i < 25; i++) begin
         d[i*8 +: 8] = pix[i];
         b.data = pix[i];
         b.user = (i == 0);
         b.eol  = (i % 5 == 4);
         b.last = (i == 24);
         sb_a.push_back(b);
      end
      s_data_a  = d;
      s_valid_a = 1'b1;
      got = 0;
      for (int t = 0; t < 500 && !got; t++) begin
         @(negedge clk);
         got = s_ready_a;
         @(posedge clk); #1;
      end
      if (!got) chk("accept_timeout_a", 32'd0, 32'd1);
      if (!keep) begin
         s_valid_a = 1'b0;
         for (int i = 0; i < 200; i += 32) s_data_a[i +: 8] = 8'($urandom);
      end
   endtask

   task automatic send_b(input pix_b_t pix, input logic [23:0] d);
      beat_t b;
      bit got;
      for (int i = 0; i < 6; i++) begin
         b.data = pix[i];
         b.user = (i == 0);
         b.eol  = (i % 3 == 2);
         b.last = (i == 5);
         sb_b.push_back(b);
      end
      s_data_b  = d;
      s_valid_b = 1'b1;
      got = 0;
      for (int t = 0; t < 500 && !got; t++) begin
         @(negedge clk);
         got = s_ready_b;
         @(posedge clk); #1;
      end
      if (!got) chk("accept_timeout_b", 32'd0, 32'd1);
      s_valid_b = 1'b0;
      s_data_b  = 24'($urandom);
   endtask

   task automatic drain_a(input int bound);
      for (int t = 0; t < bound && sb_a.size() != 0; t++) @(posedge clk);
      #1;
      chk("drain_a", 32'(sb_a.size()), 32'd0);
   endtask

   task automatic drain_b(input int bound);
      for (int t = 0; t < bound && sb_b.size() != 0; t++) @(posedge clk);
      #1;
      chk("drain_b", 32'(sb_b.size()), 32'd0);
   endtask

   initial begin
      pix_a_t pa, pa2;
      pix_b_t pb;
      logic [23:0] db;
      int start;
      s_valid_a = 0; s_data_a = '0; m_ready_a = 0;
      s_valid_b = 0; s_data_b = '0; m_ready_b = 0;
      rstn = 1'b0;
      #23;
      chk("rst_s_ready", 32'(s_ready_a), 32'd1);
      chk("rst_m_valid", 32'(m_valid_a), 32'd0);
      chk("rst_outputs", 32'({m_data_a, user_a, eol_a, last_a}), 32'd0);
      @(negedge clk) rstn = 1'b1;

      // Idle: no beats even with downstream ready
      m_ready_a = 1; m_ready_b = 1;
      start = beats_a;
      repeat (20) @(posedge clk);
      #1;
      chk("idle_no_beats", 32'(beats_a), 32'(start));
      chk("idle_s_ready", 32'(s_ready_a), 32'd1);

      // Single frame 1..25 at full rate
      for (int i = 0; i < 25; i++) pa[i] = 8'(i + 1);
      start = beats_a; gaps_a = 0; have_prev_a = 0;
      send_a(pa, 0);
      drain_a(100);
      chk("frame_beats", 32'(beats_a - start), 32'd25);
      chk("frame_gaps", 32'(gaps_a), 32'd0);

      // Two frames back-to-back, s_valid held
      for (int i = 0; i < 25; i++) begin pa[i] = 8'($urandom); pa2[i] = 8'($urandom); end
      start = beats_a; gaps_a = 0; have_prev_a = 0;
      send_a(pa, 1);
      send_a(pa2, 0);
      drain_a(200);
      chk("b2b_beats", 32'(beats_a - start), 32'd50);
      chk("b2b_gaps", 32'(gaps_a), 32'd0);

      // Random backpressure
      for (int i = 0; i < 25; i++) pa[i] = 8'(8'hA0 + i);
      rnd_a = 1;
      send_a(pa, 0);
      drain_a(2000);
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 25; i++) pa[i] = 8'($urandom);
         send_a(pa, f != 2);
      end
      drain_a(5000);
      rnd_a = 0;
      @(posedge clk); #1 m_ready_a = 1;

      // Asynchronous reset in the middle of a frame
      for (int i = 0; i < 25; i++) pa[i] = 8'($urandom);
      start = beats_a;
      send_a(pa, 0);
      for (int t = 0; t < 100 && beats_a < start + 10; t++) @(posedge clk);
      chk("reset_reach_beat10", 32'(beats_a - start), 32'd10);
      #3 rstn = 1'b0;
      #1;
      chk("midrst_m_valid", 32'(m_valid_a), 32'd0);
      chk("midrst_s_ready", 32'(s_ready_a), 32'd1);
      chk("midrst_outputs", 32'({m_data_a, user_a, eol_a, last_a}), 32'd0);
      sb_a.delete();
      sb_b.delete();
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      start = beats_a;
      repeat (20) @(posedge clk);
      #1;
      chk("post_rst_no_stale", 32'(beats_a), 32'(start));
      chk("post_rst_s_ready", 32'(s_ready_a), 32'd1);
      for (int i = 0; i < 25; i++) pa[i] = 8'($urandom);
      send_a(pa, 0);
      drain_a(100);
      chk("post_rst_frame", 32'(beats_a - start), 32'd25);

      // Small geometry: 2x3 of 4-bit pixels
      for (int i = 0; i < 6; i++) pb[i] = 8'(i + 1);
      start = beats_b;
      send_b(pb, 24'h654321);
      drain_b(50);
      chk("small_beats", 32'(beats_b - start), 32'd6);
      rnd_b = 1;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 6; i++) begin
            pb[i] = 8'($urandom_range(0, 15));
            db[i*4 +: 4] = pb[i][3:0];
         end
         send_b(pb, db);
      end
      drain_b(1000);
      rnd_b = 0;

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
